// File: rtl/lab2_serial_nibble_sub.sv
// Serial multi-nibble subtractor: D = X - Y - Bin, one 4-bit nibble per clock, LSB first.
// Optional build macro SUB_CROSSCHECK_EN adds a full-width reference check and the mismatch port.
module lab2_serial_nibble_sub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   x,
  input  logic [4*NIBBLES-1:0]   y,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   d,
  output logic                   bout
`ifdef SUB_CROSSCHECK_EN
  ,
  output logic                   mismatch
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    d_q;
  logic            bout_q;
  logic [W-1:0]    xr_q;
  logic [W-1:0]    yr_q;
  logic [W-1:0]    dr_q;
  logic            br_q;
  logic [CW-1:0]   cnt_q;

  // Same 4-bit borrow-subtract slice as the lab's 4-bit subtractors; bit 4 is the borrow.
  function automatic logic [4:0] nib_sub(input logic [3:0] a, input logic [3:0] b,
                                         input logic bi);
    return {1'b0, a} - {1'b0, b} - {4'b0000, bi};
  endfunction

  logic [3:0] xn_d;
  logic [3:0] yn_d;
  logic [4:0] t_d;
  logic       last_d;

  assign xn_d   = xr_q[4*cnt_q +: 4];
  assign yn_d   = yr_q[4*cnt_q +: 4];
  assign t_d    = nib_sub(xn_d, yn_d, br_q);
  assign last_d = (cnt_q == CW'(NIBBLES - 1));

`ifdef SUB_CROSSCHECK_EN
  logic         bl_q;
  logic         mm_q;
  logic [W:0]   ref_d;

  assign ref_d    = {1'b0, xr_q} - {1'b0, yr_q} - {{W{1'b0}}, bl_q};
  assign mismatch = mm_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      xr_q    <= '0;
      yr_q    <= '0;
      dr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SUB_CROSSCHECK_EN
      bl_q    <= 1'b0;
      mm_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            xr_q    <= x;
            yr_q    <= y;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
`ifdef SUB_CROSSCHECK_EN
            bl_q    <= bin;
`endif
          end
        end
        S_RUN: begin
          dr_q[4*cnt_q +: 4] <= t_d[3:0];
          br_q               <= t_d[4];
          if (last_d) state_q <= S_DONE;
          else        cnt_q   <= cnt_q + 1'b1;
        end
        S_DONE: begin
          // Result is published only here, so d/bout never show partial values.
          d_q     <= dr_q;
          bout_q  <= br_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`ifdef SUB_CROSSCHECK_EN
          if (ref_d != {br_q, dr_q}) mm_q <= 1'b1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule
